// File: rtl/serieller_addierer_steuerung.sv
// rtl/serieller_addierer_steuerung.sv - bit-serial adder controller driving one shared full-adder cell
// Optional feature: define SUBTRAKTION_EN to add the subtrahieren port (a - b via ~b plus carry 1).

module volladdierer (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic summe,
  output logic uebertrag
);
  assign summe     = a ^ b ^ c;
  assign uebertrag = (a & b) | (a & c) | (b & c);
endmodule

module serieller_addierer_steuerung #(
  parameter int BREITE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BREITE-1:0] a,
  input  logic [BREITE-1:0] b,
  input  logic              uebertrag_ein,
`ifdef SUBTRAKTION_EN
  input  logic              subtrahieren,
`endif
  output logic              bereit,
  output logic              fertig,
  output logic [BREITE-1:0] summe,
  output logic              uebertrag_aus
);
  localparam int ZW = (BREITE > 1) ? $clog2(BREITE) : 1;

  typedef enum logic [1:0] {LEER, RECHNEN, FERTIG} zustand_t;

  zustand_t          zustand;
  logic [BREITE-1:0] op_a;
  logic [BREITE-1:0] op_b;
  logic              uebertrag_reg;
  logic [ZW-1:0]     zaehler;
  logic [BREITE-1:0] b_lade;
  logic              c_lade;
  logic              fa_summe;
  logic              fa_uebertrag;

  // Subtraction reuses the adder: a + ~b + 1.
  always_comb begin
    b_lade = b;
    c_lade = uebertrag_ein;
`ifdef SUBTRAKTION_EN
    if (subtrahieren) begin
      b_lade = ~b;
      c_lade = 1'b1;
    end
`endif
  end

  volladdierer u_volladdierer (
    .a         (op_a[zaehler]),
    .b         (op_b[zaehler]),
    .c         (uebertrag_reg),
    .summe     (fa_summe),
    .uebertrag (fa_uebertrag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zustand       <= LEER;
      bereit        <= 1'b1;
      fertig        <= 1'b0;
      summe         <= '0;
      uebertrag_aus <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      uebertrag_reg <= 1'b0;
      zaehler       <= '0;
    end else begin
      case (zustand)
        LEER: begin
          if (start) begin
            op_a          <= a;
            op_b          <= b_lade;
            uebertrag_reg <= c_lade;
            zaehler       <= '0;
            summe         <= '0;
            uebertrag_aus <= 1'b0;
            bereit        <= 1'b0;
            zustand       <= RECHNEN;
          end
        end
        RECHNEN: begin
          summe[zaehler] <= fa_summe;
          uebertrag_reg  <= fa_uebertrag;
          zaehler        <= zaehler + ZW'(1);
          if (zaehler == ZW'(BREITE - 1)) begin
            uebertrag_aus <= fa_uebertrag;
            fertig        <= 1'b1;
            zustand       <= FERTIG;
          end
        end
        FERTIG: begin
          fertig  <= 1'b0;
          bereit  <= 1'b1;
          zustand <= LEER;
        end
        default: begin
          fertig  <= 1'b0;
          bereit  <= 1'b1;
          zustand <= LEER;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serieller_addierer_steuerung.sv
// tb/tb_serieller_addierer_steuerung.sv - randomized self-checking bench for serieller_addierer_steuerung
// Honours SUBTRAKTION_EN when defined.

module tb_serieller_addierer_steuerung;
  localparam int BREITE = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [BREITE-1:0] a = '0;
  logic [BREITE-1:0] b = '0;
  logic              uebertrag_ein = 1'b0;
  logic              subtrahieren = 1'b0;
  logic              bereit;
  logic              fertig;
  logic [BREITE-1:0] summe;
  logic              uebertrag_aus;

  int n_vergleich = 0;
  int n_fehler = 0;

  always #5 clk = ~clk;

  serieller_addierer_steuerung #(.BREITE(BREITE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a             (a),
    .b             (b),
    .uebertrag_ein (uebertrag_ein),
`ifdef SUBTRAKTION_EN
    .subtrahieren  (subtrahieren),
`endif
    .bereit        (bereit),
    .fertig        (fertig),
    .summe         (summe),
    .uebertrag_aus (uebertrag_aus)
  );

  task automatic pruefe(input string tag, input logic [31:0] ist, input logic [31:0] soll);
    n_vergleich++;
    if (ist !== soll) begin
      n_fehler++;
      $display("FAIL %s: ist=0x%0h soll=0x%0h", tag, ist, soll);
    end
  endtask

  task automatic takt;
    @(posedge clk);
    #1;
  endtask

  // Reference: exact (BREITE+1)-bit arithmetic.
  function automatic logic [BREITE:0] modell(input logic [BREITE-1:0] xa, xb,
                                              input logic xc, input logic xs);
    logic [BREITE-1:0] nb;
    nb = ~xb;
    if (xs) return {1'b0, xa} + {1'b0, nb} + (BREITE+1)'(1);
    return {1'b0, xa} + {1'b0, xb} + {{BREITE{1'b0}}, xc};
  endfunction

  task automatic operation(input logic [BREITE-1:0] xa, xb, input logic xc,
                           input logic xs, input bit halten, input string tag);
    logic [BREITE:0] soll;
    int lat;
    int warte;
    soll = modell(xa, xb, xc, xs);
    warte = 0;
    while (!bereit && warte < 40) begin
      takt();
      warte++;
    end
    pruefe({tag, "_bereit_vor"}, bereit, 1);
    a = xa; b = xb; uebertrag_ein = xc; subtrahieren = xs; start = 1'b1;
    takt();
    if (!halten) start = 1'b0;
    pruefe({tag, "_bereit_nach_start"}, bereit, 0);
    lat = 0;
    while (!fertig && lat < 40) begin
      if (halten) begin
        a = BREITE'($urandom); b = BREITE'($urandom); uebertrag_ein = 1'($urandom);
      end
      takt();
      lat++;
    end
    start = 1'b0;
    pruefe({tag, "_latenz"}, lat, BREITE);
    pruefe({tag, "_summe"}, summe, soll[BREITE-1:0]);
    pruefe({tag, "_uebertrag"}, uebertrag_aus, soll[BREITE]);
    takt();
    pruefe({tag, "_fertig_ende"}, fertig, 0);
    pruefe({tag, "_bereit_ende"}, bereit, 1);
    pruefe({tag, "_summe_gehalten"}, summe, soll[BREITE-1:0]);
  endtask

  task automatic keine_fertig(input string tag, input int zyklen);
    int anzahl;
    anzahl = 0;
    for (int i = 0; i < zyklen; i++) begin
      takt();
      if (fertig) anzahl++;
    end
    pruefe(tag, anzahl, 0);
  endtask

  initial begin
    int runden;
    logic xs;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      pruefe("leer_bereit", bereit, 1);
      pruefe("leer_fertig", fertig, 0);
      pruefe("leer_summe", summe, 0);
      pruefe("leer_uebertrag", uebertrag_aus, 0);
      takt();
    end

    operation(8'hFF, 8'h01, 1'b0, 1'b0, 0, "ff_plus_01");
    operation(8'h5A, 8'h33, 1'b1, 1'b0, 0, "5a_plus_33");
    operation(8'h80, 8'h80, 1'b0, 1'b0, 0, "80_plus_80");
    pruefe("80_plus_80_wert", summe, 8'h00);

    operation(8'hC3, 8'h7E, 1'b1, 1'b0, 1, "start_gehalten");
    keine_fertig("start_gehalten_kein_zweites", BREITE + 2);

    a = 8'h9C; b = 8'h21; uebertrag_ein = 1'b0; subtrahieren = 1'b0; start = 1'b1;
    takt();
    start = 1'b0;
    repeat (3) takt();
    rst_n = 1'b0;
    #1;
    pruefe("reset_bereit", bereit, 1);
    pruefe("reset_fertig", fertig, 0);
    pruefe("reset_summe", summe, 0);
    pruefe("reset_uebertrag", uebertrag_aus, 0);
    takt();
    rst_n = 1'b1;
    keine_fertig("reset_kein_fertig", BREITE + 2);
    operation(8'h12, 8'h34, 1'b0, 1'b0, 0, "nach_reset");
    pruefe("nach_reset_wert", summe, 8'h46);

`ifdef SUBTRAKTION_EN
    operation(8'h10, 8'h01, 1'b0, 1'b1, 0, "sub_10_01");
    pruefe("sub_10_01_wert", summe, 8'h0F);
    operation(8'h01, 8'h02, 1'b1, 1'b1, 0, "sub_01_02");
    pruefe("sub_01_02_wert", summe, 8'hFF);
`endif

    runden = 20;
    for (int i = 0; i < runden; i++) begin
      xs = 1'b0;
`ifdef SUBTRAKTION_EN
      xs = 1'($urandom);
`endif
      operation(BREITE'($urandom), BREITE'($urandom), 1'($urandom), xs, 0, "zufall");
      repeat ($urandom_range(0, 2)) takt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_vergleich, n_fehler);
    $finish;
  end
endmodule
